// File: rtl/param_input_fifo.sv
// Parametrised input FIFO with watermarks, sticky error flags and exact count.
// Define PARAM_INPUT_FIFO_FWFT_EN for first-word fall-through output.
module param_input_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_MODES     = 4,
  parameter int RES_WIDTH     = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  localparam int W  = DATA_WIDTH + NUM_MODES + RES_WIDTH,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          EN,
  input  logic          Clr,
  input  logic          WR,
  input  logic [W-1:0]  dataIn,
  input  logic          RD,
  output logic [W-1:0]  dataOut,
  output logic          dataValid,
  output logic          EMPTY,
  output logic          FULL,
  output logic          AFULL,
  output logic          AEMPTY,
  output logic [CW-1:0] Count,
  output logic          OVF,
  output logic          UDF
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [PW-1:0] w_rd_nxt;
  logic [PW-1:0] w_wr_nxt;

  assign EMPTY  = (r_count == '0);
  assign FULL   = (r_count == CW'(FIFO_DEPTH));
  assign AFULL  = (int'(r_count) >= AFULL_THRESH);
  assign AEMPTY = (int'(r_count) <= AEMPTY_THRESH);
  assign Count  = r_count;
  assign OVF    = r_ovf;
  assign UDF    = r_udf;

  // A full FIFO still takes a write when the same cycle frees a slot
  assign w_rd_acc = RD && !EMPTY;
  assign w_wr_acc = WR && (!FULL || w_rd_acc);

  assign w_rd_nxt = (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_nxt = (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (Clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (EN) begin
      if (w_rd_acc) r_rd_ptr <= w_rd_nxt;
      if (w_wr_acc) r_wr_ptr <= w_wr_nxt;
      unique case (1'b1)
        (w_wr_acc && !w_rd_acc): r_count <= r_count + CW'(1);
        (w_rd_acc && !w_wr_acc): r_count <= r_count - CW'(1);
        default:                 r_count <= r_count;
      endcase
      if (RD && EMPTY)     r_udf <= 1'b1;
      if (WR && !w_wr_acc) r_ovf <= 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge Clk) begin
    if (Rst_n && !Clr && EN && w_wr_acc) begin
      r_mem[r_wr_ptr] <= dataIn;
    end
  end

`ifdef PARAM_INPUT_FIFO_FWFT_EN
  assign dataOut   = r_mem[r_rd_ptr];
  assign dataValid = !EMPTY;
`else
  logic [W-1:0] r_dout;
  logic         r_dvalid;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else if (Clr) begin
      r_dvalid <= 1'b0;
    end else if (EN) begin
      r_dvalid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
    end else begin
      r_dvalid <= 1'b0;
    end
  end

  assign dataOut   = r_dout;
  assign dataValid = r_dvalid;
`endif

endmodule

// File: tb/tb_param_input_fifo.sv
// Bench for param_input_fifo: depth-16 and depth-5 instances share stimulus
// and are compared every cycle against a queue model, plus directed tables.
module tb_param_input_fifo;

  localparam int W = 44;

  logic         Clk, Rst_n, EN, Clr, WR, RD;
  logic [W-1:0] dataIn;

  logic [W-1:0] do16, do5;
  logic         dv16, dv5, e16, e5, f16, f5;
  logic         af16, af5, ae16, ae5, o16, o5, u16, u5;
  logic [4:0]   c16;
  logic [2:0]   c5;

  param_input_fifo #(.FIFO_DEPTH(16)) dut16 (
    .Clk(Clk), .Rst_n(Rst_n), .EN(EN), .Clr(Clr), .WR(WR),
    .dataIn(dataIn), .RD(RD), .dataOut(do16), .dataValid(dv16),
    .EMPTY(e16), .FULL(f16), .AFULL(af16), .AEMPTY(ae16),
    .Count(c16), .OVF(o16), .UDF(u16)
  );

  param_input_fifo #(.FIFO_DEPTH(5)) dut5 (
    .Clk(Clk), .Rst_n(Rst_n), .EN(EN), .Clr(Clr), .WR(WR),
    .dataIn(dataIn), .RD(RD), .dataOut(do5), .dataValid(dv5),
    .EMPTY(e5), .FULL(f5), .AFULL(af5), .AEMPTY(ae5),
    .Count(c5), .OVF(o5), .UDF(u5)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq [2][$];
  logic [W-1:0] m_dout [2];
  logic         m_dv  [2];
  logic         m_ovf [2];
  logic         m_udf [2];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int dep;
      bit ra, wa;
      dep = (d == 0) ? 16 : 5;
      if (!Rst_n) begin
        mq[d].delete();
        m_dout[d] = '0;
        m_dv[d] = 0; m_ovf[d] = 0; m_udf[d] = 0;
      end else if (Clr) begin
        mq[d].delete();
        m_dv[d] = 0; m_ovf[d] = 0; m_udf[d] = 0;
      end else if (EN) begin
        ra = RD && (mq[d].size() > 0);
        wa = WR && ((mq[d].size() < dep) || ra);
        if (RD && !ra) m_udf[d] = 1;
        if (WR && !wa) m_ovf[d] = 1;
        m_dv[d] = ra;
        if (ra) m_dout[d] = mq[d].pop_front();
        if (wa) mq[d].push_back(dataIn);
      end else begin
        m_dv[d] = 0;
      end
    end
  endtask

  function automatic logic [63:0] expv(input int d);
    int dep, n;
    dep = (d == 0) ? 16 : 5;
    n = mq[d].size();
    return {8'b0, m_dout[d], m_dv[d], n == 0, n == dep, n >= dep - 2,
            n <= 2, m_ovf[d], m_udf[d], 5'(n)};
  endfunction

  function automatic logic [63:0] act16();
    return {8'b0, do16, dv16, e16, f16, af16, ae16, o16, u16, c16};
  endfunction

  function automatic logic [63:0] act5();
    return {8'b0, do5, dv5, e5, f5, af5, ae5, o5, u5, 2'b0, c5};
  endfunction

  task automatic cyc(input logic wr, input logic rd, input logic en,
                     input logic clr, input logic [W-1:0] din);
    WR = wr; RD = rd; EN = en; Clr = clr; dataIn = din;
    @(posedge Clk);
    model_step();
    #1;
    chk("model16", act16(), expv(0));
    chk("model5", act5(), expv(1));
  endtask

  typedef struct {
    logic         wr, rd, en, clr;
    logic [W-1:0] din;
    logic [4:0]   cnt;
    logic         ovf, udf, dv;
    logic [W-1:0] dout;
  } vec_t;

  vec_t tv [12];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 44'h11, 5'd1, 1'b0, 1'b0, 1'b0, 44'h0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 44'h22, 5'd2, 1'b0, 1'b0, 1'b0, 44'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 44'h0,  5'd1, 1'b0, 1'b0, 1'b1, 44'h11};
    tv[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 44'h33, 5'd1, 1'b0, 1'b0, 1'b1, 44'h22};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 44'h44, 5'd1, 1'b0, 1'b0, 1'b0, 44'h0};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 44'h0,  5'd0, 1'b0, 1'b0, 1'b1, 44'h33};
    tv[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 44'h0,  5'd0, 1'b0, 1'b1, 1'b0, 44'h0};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 44'h55, 5'd1, 1'b0, 1'b1, 1'b0, 44'h0};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 44'h66, 5'd2, 1'b0, 1'b1, 1'b0, 44'h0};
    tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 44'h77, 5'd0, 1'b0, 1'b0, 1'b0, 44'h0};
    tv[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 44'h88, 5'd0, 1'b0, 1'b0, 1'b0, 44'h0};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 44'h99, 5'd1, 1'b0, 1'b0, 1'b0, 44'h0};

    Rst_n = 1'b0; EN = 1'b0; Clr = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
    #12;
    model_step();
    chk("reset16", act16(), {8'b0, 44'h0, 7'b0100100, 5'd0});
    chk("reset5", act5(), {8'b0, 44'h0, 7'b0100100, 5'd0});
    Rst_n = 1'b1;

    // Table of short sequences with hand-derived results
    cyc(0, 0, 1, 1, '0);
    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].wr, tv[i].rd, tv[i].en, tv[i].clr, tv[i].din);
      chk($sformatf("tv%0d", i),
          {4'b0, c16, o16, u16, dv16, (tv[i].dv ? do16 : 44'h0)},
          {4'b0, tv[i].cnt, tv[i].ovf, tv[i].udf, tv[i].dv, tv[i].dout});
    end

    // Fill to full, overflow, then drain and underflow
    cyc(0, 0, 1, 1, '0);
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 1, 0, W'(i));
      chk("afull", {63'b0, af16}, {63'b0, i >= 14});
    end
    chk("full", {58'b0, f16, c16}, {58'b0, 1'b1, 5'd16});
    cyc(1, 0, 1, 0, 44'h99);
    chk("ovf", {58'b0, o16, c16}, {58'b0, 1'b1, 5'd16});
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 1, 0, '0);
      chk("drain", {19'b0, dv16, do16}, {19'b0, 1'b1, W'(i)});
    end
    chk("empty", {63'b0, e16}, 64'd1);
    cyc(0, 1, 1, 0, '0);
    chk("udf", {58'b0, u16, c16}, {58'b0, 1'b1, 5'd0});

    // Simultaneous read and write while full
    cyc(0, 0, 1, 1, '0);
    for (int i = 1; i <= 16; i++) cyc(1, 0, 1, 0, W'(i));
    cyc(1, 1, 1, 0, 44'h77);
    chk("rdwr_full", {12'b0, c16, o16, f16, do16},
        {12'b0, 5'd16, 1'b0, 1'b1, 44'h1});

    // Pointer wrap on the depth-5 instance
    cyc(0, 0, 1, 1, '0);
    for (int i = 0; i < 13; i++) begin
      cyc(1, 0, 1, 0, W'(256 + i));
      cyc(0, 1, 1, 0, '0);
      chk("wrap5", {19'b0, dv5, do5}, {19'b0, 1'b1, W'(256 + i)});
    end

    // Enable freeze, then clear of sticky flags
    cyc(0, 0, 1, 1, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, W'(i + 5));
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 44'hF0);
      chk("freeze", {56'b0, c16, o16, u16, dv16}, {56'b0, 5'd3, 3'b000});
    end
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, W'(i + 9));
    chk("ovf5", {60'b0, o5, c5}, {60'b0, 1'b1, 3'd5});
    cyc(0, 0, 1, 1, '0);
    chk("clr5", {60'b0, o5, c5}, 64'd0);
    cyc(0, 1, 1, 0, '0);
    cyc(0, 0, 0, 1, '0);
    chk("clr_udf", {58'b0, u16, c16}, 64'd0);

    // Asynchronous reset in the middle of a write
    cyc(1, 0, 1, 0, 44'h123);
    cyc(1, 1, 1, 0, 44'h456);
    WR = 1'b1; RD = 1'b1; dataIn = 44'h789;
    @(posedge Clk);
    model_step();
    #3;
    Rst_n = 1'b0;
    #1;
    chk("async16", act16(), {8'b0, 44'h0, 7'b0100100, 5'd0});
    chk("async5", act5(), {8'b0, 44'h0, 7'b0100100, 5'd0});
    model_step();
    @(negedge Clk);
    Rst_n = 1'b1; WR = 1'b0; RD = 1'b0;

    // Randomized traffic with fill-biased and drain-biased phases
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] r;
      int ph;
      ph = (c / 150) % 2;
      r = {$urandom(), $urandom()};
      cyc($urandom_range(0, 99) < (ph ? 75 : 30),
          $urandom_range(0, 99) < (ph ? 30 : 75),
          $urandom_range(0, 99) < 90,
          $urandom_range(0, 99) < 2,
          r[W-1:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
